// File: rtl/cookie_display_pkg.sv
// Shared types and constants for the decimal debug display driver.
package cookie_display_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment code with every segment and the DP off
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low codes for digits 0..9: bit0=a .. bit6=g, bit7=DP (kept off)
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_t;

endpackage

// File: rtl/seg7_decimal_encode.sv
// One decimal digit to an active-low 7-segment code, with a blanking override.
module seg7_decimal_encode
  import cookie_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Anything above 9 shows blank; the converter never produces such a nibble
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) begin
      seg_o = SEG_DIGIT[digit_i];
    end
  end

endmodule

// File: rtl/debug_decimal_display_driver.sv
// Samples a debug value, converts it to six BCD digits with a bit-serial
// double-dabble engine and drives registered active-low codes to HEX0..HEX5.
//
// Handshake: sample_req is a single-cycle strobe with no ready. A request (or
// refresh tick) in IDLE starts a conversion; one arriving while busy is held
// as a single pending request and serviced from IDLE right after COMMIT,
// sampling value_in at that time. done pulses for one cycle when hex_display
// takes its new value.
module debug_decimal_display_driver
  import cookie_display_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int REFRESH_CYCLES = 4500000
) (
  input  logic                             main_clk,
  input  logic                             reset_n,
  input  logic [WIDTH-1:0]                 value_in,
  input  logic                             sample_req,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_DIGITS-1:0][7:0]       hex_display,
  output disp_state_t                      dbg_state_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  disp_state_t                       state_q;
  logic [WIDTH-1:0]                  shift_q;
  logic [4*NUM_DIGITS-1:0]           bcd_q;
  logic [4*NUM_DIGITS-1:0]           bcd_adj_d;
  logic [BW-1:0]                     bitcnt_q;
  logic                              pending_q;
  logic                              done_q;
  logic [NUM_DIGITS-1:0][7:0]        hex_q;
  logic [NUM_DIGITS-1:0][7:0]        seg_code;
  logic [NUM_DIGITS-1:0]             blank;
  logic                              seen_nonzero;
  logic                              tick;
  logic                              req;
  logic                              trigger;

  generate
    if (REFRESH_CYCLES == 0) begin : g_no_refresh
      assign tick = 1'b0;
    end else begin : g_refresh
      localparam logic [RW-1:0] TERM = RW'(REFRESH_CYCLES - 1);
      logic [RW-1:0] refresh_q;
      assign tick = (refresh_q == TERM);
      // Free-running refresh counter, wraps on terminal count in every state
      always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
          refresh_q <= '0;
        end else if (tick) begin
          refresh_q <= '0;
        end else begin
          refresh_q <= refresh_q + 1'b1;
        end
      end
    end
  endgenerate

  assign req     = sample_req | tick;
  assign trigger = req | pending_q;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: scan from the top digit, digit 0 always shown
  always_comb begin
    seen_nonzero = 1'b0;
    blank        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        seen_nonzero = 1'b1;
      end
      blank[i] = !seen_nonzero && (i != 0);
    end
  end

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      seg7_decimal_encode u_enc (
        .digit_i (bcd_q[4*g +: 4]),
        .blank_i (blank[g]),
        .seg_o   (seg_code[g])
      );
    end
  endgenerate

  // Conversion FSM: capture, one bit per SHIFT cycle, single-cycle COMMIT
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bitcnt_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      hex_q     <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            shift_q   <= value_in;
            bcd_q     <= '0;
            bitcnt_q  <= BW'(WIDTH - 1);
            pending_q <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (req) pending_q <= 1'b1;
          bcd_q   <= (4*NUM_DIGITS)'({bcd_adj_d, shift_q[WIDTH-1]});
          shift_q <= shift_q << 1;
          if (bitcnt_q == '0) begin
            state_q <= COMMIT;
          end else begin
            bitcnt_q <= bitcnt_q - 1'b1;
          end
        end
        COMMIT: begin
          if (req) pending_q <= 1'b1;
          hex_q   <= seg_code;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == SHIFT) || (state_q == COMMIT);
  assign done        = done_q;
  assign hex_display = hex_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_debug_decimal_display_driver.sv
// Directed bench for debug_decimal_display_driver: latency, busy width,
// digit encoding and blanking, pending merge, async reset, auto-refresh.
module tb_debug_decimal_display_driver;
  import cookie_display_pkg::*;

  localparam logic [47:0] ALL_BLANK = 48'hFFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic main_clk = 1'b0;
  logic reset_n;
  always #5 main_clk = ~main_clk;

  // main instance: auto-refresh disabled
  logic [15:0]       value_in;
  logic              sample_req;
  logic              busy;
  logic              done;
  logic [5:0][7:0]   hex_display;
  disp_state_t       dbg_state;

  // second instance: refresh every 100 cycles
  logic [15:0]       ref_value;
  logic              ref_req;
  logic              ref_busy;
  logic              ref_done;
  logic [5:0][7:0]   ref_hex;
  disp_state_t       ref_state;

  debug_decimal_display_driver #(.WIDTH(16), .REFRESH_CYCLES(0)) u_dut (
    .main_clk    (main_clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .sample_req  (sample_req),
    .busy        (busy),
    .done        (done),
    .hex_display (hex_display),
    .dbg_state_o (dbg_state)
  );

  debug_decimal_display_driver #(.WIDTH(16), .REFRESH_CYCLES(100)) u_ref (
    .main_clk    (main_clk),
    .reset_n     (reset_n),
    .value_in    (ref_value),
    .sample_req  (ref_req),
    .busy        (ref_busy),
    .done        (ref_done),
    .hex_display (ref_hex),
    .dbg_state_o (ref_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge just after the edge that saw the request
  task automatic pulse_req();
    @(negedge main_clk);
    sample_req = 1'b1;
    @(negedge main_clk);
    sample_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output int busy_cnt, output bit seen);
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    seen     = 1'b0;
    while (!seen && lat < budget) begin
      @(negedge main_clk);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic wait_ref_done(input int budget, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < budget) begin
      @(negedge main_clk);
      lat++;
      if (ref_done) seen = 1'b1;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge main_clk);
      if (done) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] vec_val [4];
  logic [47:0] vec_exp [4];

  initial begin
    int lat, bcnt, n;
    bit seen;

    vec_val[0] = 16'd0;     vec_exp[0] = 48'hFF_FF_FF_FF_FF_C0;
    vec_val[1] = 16'd65535; vec_exp[1] = 48'hFF_82_92_92_B0_92;
    vec_val[2] = 16'd1000;  vec_exp[2] = 48'hFF_FF_F9_C0_C0_C0;
    vec_val[3] = 16'd40960; vec_exp[3] = 48'hFF_99_C0_90_82_C0;

    reset_n    = 1'b0;
    sample_req = 1'b0;
    value_in   = '0;
    ref_req    = 1'b0;
    ref_value  = 16'd12345;
    repeat (3) @(negedge main_clk);
    check("rst_hex", hex_display, ALL_BLANK);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    reset_n = 1'b1;

    // idle with no trigger: stays blank, no done
    count_done(50, n);
    check("idle_no_done", 48'(n), 48'd0);
    check("idle_hex", hex_display, ALL_BLANK);
    check("idle_busy", 48'(busy), 48'd0);
    check("idle_state", 48'(dbg_state), 48'(IDLE));

    // single conversions
    for (int v = 0; v < 4; v++) begin
      value_in = vec_val[v];
      exp_q.push_back(vec_exp[v]);
      pulse_req();
      wait_done(40, lat, bcnt, seen);
      check($sformatf("conv%0d_seen", v), 48'(seen), 48'd1);
      check($sformatf("conv%0d_lat", v), 48'(lat), 48'd17);
      check($sformatf("conv%0d_busy", v), 48'(bcnt), 48'd17);
      check($sformatf("conv%0d_hex", v), hex_display, exp_q.pop_front());
      @(negedge main_clk);
      check($sformatf("conv%0d_done_1cyc", v), 48'(done), 48'd0);
    end

    // requests while busy merge into one pending conversion sampled later
    value_in = 16'd7;
    pulse_req();
    repeat (2) @(negedge main_clk);
    value_in   = 16'd42;
    sample_req = 1'b1;
    @(negedge main_clk);
    sample_req = 1'b0;
    repeat (4) @(negedge main_clk);
    sample_req = 1'b1;
    @(negedge main_clk);
    sample_req = 1'b0;
    wait_done(40, lat, bcnt, seen);
    check("pend_first_seen", 48'(seen), 48'd1);
    check("pend_first_hex", hex_display, 48'hFF_FF_FF_FF_FF_F8);
    wait_done(40, lat, bcnt, seen);
    check("pend_second_seen", 48'(seen), 48'd1);
    check("pend_second_lat", 48'(lat), 48'd18);
    check("pend_second_hex", hex_display, 48'hFF_FF_FF_FF_99_A4);
    count_done(60, n);
    check("pend_no_third", 48'(n), 48'd0);

    // async reset in the middle of SHIFT
    value_in = 16'd500;
    pulse_req();
    repeat (5) @(negedge main_clk);
    check("midrst_state_before", 48'(dbg_state), 48'(SHIFT));
    #2 reset_n = 1'b0;
    #1;
    check("midrst_hex", hex_display, ALL_BLANK);
    check("midrst_busy", 48'(busy), 48'd0);
    check("midrst_done", 48'(done), 48'd0);
    check("midrst_state", 48'(dbg_state), 48'(IDLE));
    @(negedge main_clk);
    reset_n = 1'b1;
    count_done(40, n);
    check("midrst_no_done", 48'(n), 48'd0);
    check("midrst_idle", 48'(dbg_state), 48'(IDLE));
    check("midrst_hex_after", hex_display, ALL_BLANK);

    // auto-refresh instance: done every 100 cycles showing 12345
    wait_ref_done(250, lat, seen);
    check("ref_first_seen", 48'(seen), 48'd1);
    check("ref_hex", ref_hex, 48'hFF_F9_A4_B0_99_92);
    for (int p = 0; p < 2; p++) begin
      wait_ref_done(250, lat, seen);
      check($sformatf("ref_period%0d", p), 48'(lat), 48'd100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_decimal_display_driver.md
Name: debug_decimal_display_driver

Overview:
- Sequential replacement for the combinational base-10 debug display path on the DE10-Lite top level.
- Samples a selected debug value from core_main, such as a user register chosen by SW[3:0].
- Converts it to six decimal digits with an iterative double-dabble engine, one bit per cycle.
- Applies leading-zero blanking, then drives registered, glitch-free active-low 7-segment codes to HEX0..HEX5.

Parameters:
- WIDTH, 16, bit width of value_in; legal range 1..19 so the maximum value fits in 6 decimal digits.
- REFRESH_CYCLES, 4500000, main_clk cycles between automatic samples (50 ms at 90 MHz); 0 disables auto-refresh.

Ports:
- main_clk  input  1  system clock, 90 MHz PLL output; all logic on this one clock.
- reset_n  input  1  asynchronous, active-low reset.
- value_in  input  WIDTH  unsigned value to display; sampled only at capture.
- sample_req  input  1  single-cycle request for an immediate sample.
- busy  output  1  high while a conversion is in progress (states SHIFT and COMMIT).
- done  output  1  one-cycle pulse on the cycle the display outputs update.
- hex_display  output  6x8  per-digit segment codes; [0] is the least significant digit (HEX0); bit0=a..bit6=g, bit7=DP; active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately): every hex_display entry = 8'hFF (blank); busy=0; done=0; state=IDLE; pending=0; refresh counter=0; shift and BCD registers=0.
- Reset asserted mid-conversion: the conversion is aborted and outputs return to blank; no done pulse.
- Refresh counter: free-running 0..REFRESH_CYCLES-1 in every state; it produces tick on terminal count and wraps to 0.
- States: IDLE, SHIFT, COMMIT.
- IDLE, trigger = sample_req | tick | pending:
  - capture value_in into the shift register; clear the 24-bit BCD register;
  - set bit counter = WIDTH-1; clear pending; go to SHIFT.
- SHIFT, one cycle per bit, exactly WIDTH cycles:
  - each BCD nibble >= 5 gets +3, all nibbles in parallel;
  - then {bcd, shift} shift left by 1;
  - on counter == 0, go to COMMIT; otherwise decrement.
- COMMIT, single cycle:
  - register the encoded digits into hex_display;
  - done=1 for this cycle only;
  - go to IDLE.
- Latency: trigger seen on edge k; hex_display and done update on edge k+WIDTH+1.
- busy is high for the WIDTH+1 cycles after edge k.
- Back-to-back: with pending set, the next capture occurs on the first edge after COMMIT.
- Trigger (sample_req or tick) while busy: sets pending. At most one pending conversion; extra requests merge into it. The new value is sampled at service time, not at request time.
- sample_req and tick in the same IDLE cycle: one conversion only.
- Leading-zero blanking:
  - digit i is blank (8'hFF) if digits i..5 are all zero and i > 0;
  - digit 0 is always shown, so value 0 displays "0".
- DP is always off (bit7=1).
- Segment codes (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- BCD nibbles never exceed 9 after the final shift. The encoder maps any value above 9 to blank, which is defensive and unreachable.
- Outputs change only at COMMIT, so there are no intermediate or partial patterns.

Decomposition:
- Package cookie_display_pkg holds:
  - state enum disp_state_t {IDLE, SHIFT, COMMIT};
  - localparam SEG_BLANK=8'hFF;
  - segment constant array SEG_DIGIT[0:9];
  - NUM_DIGITS=6.
- Sub-module seg7_decimal_encode: combinational; 4-bit digit plus blank flag in, 8-bit active-low code out. The driver instantiates it six times.

Test Plan:
- Reset with REFRESH_CYCLES=0, then no trigger -> all hex_display = FF, busy=0, done=0 indefinitely.
- value_in=0, sample_req pulse -> done exactly 17 cycles later; HEX0=C0, HEX1..HEX5=FF.
- value_in=65535, sample_req -> HEX4..HEX0 = 82,92,92,B0,92 ("65535"); HEX5=FF; busy high for 17 cycles.
- value_in=1000 -> HEX3=F9, HEX2..HEX0=C0, HEX5..HEX4=FF.
- value_in=7, then change value_in to 42 and pulse sample_req during busy, then 9 during busy:
  - first done shows "7";
  - second conversion starts the edge after COMMIT and shows "42" (HEX1=99, HEX0=A4);
  - only two done pulses total.
- Set REFRESH_CYCLES=100; value_in=12345 -> a done pulse every 100 cycles.
- Assert reset_n low mid-SHIFT -> outputs FF asynchronously, no done pulse, IDLE after release.
